// File: rtl/sys_cmd_pkg.sv
// Shared types and constants for the UART command controller: FSM states,
// command bytes and the fixed ALU operand register addresses.
package sys_cmd_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StRdAddr,
        StRdWait,
        StOpA,
        StOpB,
        StFun,
        StAluWait,
        StTxLo,
        StTxHi
    } sys_cmd_state_e;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OP_A_ADDR = 0;
    localparam int unsigned OP_B_ADDR = 1;

endpackage

// File: rtl/sys_cmd_tx_push.sv
// Two-byte TX FIFO pusher: presents the low or high byte of a captured
// response and raises a write strobe only while the FIFO has room.
module sys_cmd_tx_push #(
    parameter int unsigned DATA_W = 8
) (
    input  logic                  tx_lo_i,
    input  logic                  tx_hi_i,
    input  logic [2*DATA_W-1:0]   data_i,
    input  logic                  tx_full_i,
    output logic [DATA_W-1:0]     tx_data_o,
    output logic                  tx_wr_o
);

    always_comb begin
        tx_data_o = '0;
        if (tx_lo_i) begin
            tx_data_o = data_i[DATA_W-1:0];
        end else if (tx_hi_i) begin
            tx_data_o = data_i[2*DATA_W-1:DATA_W];
        end
    end

    // Data stays on the bus while full; the strobe waits for space.
    assign tx_wr_o = (tx_lo_i || tx_hi_i) && !tx_full_i;

endmodule

// File: rtl/sys_cmd_ctrl.sv
// UART command decoder driving a register file, an ALU and a TX FIFO.
// Optional inter-byte timeout enabled by defining SYS_CMD_TMO_EN.
module sys_cmd_ctrl
    import sys_cmd_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned TMO_CYC = 4096
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_W-1:0]     RX_P_DATA,
    input  logic                  RX_D_VLD,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_W-1:0]     Address,
    output logic [DATA_W-1:0]     WrData,
    input  logic [DATA_W-1:0]     RdData,
    input  logic                  RdData_Valid,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    output logic                  CLK_EN,
    input  logic [2*DATA_W-1:0]   ALU_OUT,
    input  logic                  OUT_Valid,
    output logic [DATA_W-1:0]     TX_P_DATA,
    output logic                  TX_WR,
    input  logic                  TX_FULL
);

    sys_cmd_state_e          state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;
    logic                    alu_en_q, alu_en_d;
    logic                    clk_en_q, clk_en_d;
    logic [3:0]              fun_q, fun_d;
    logic [2*DATA_W-1:0]     result_q, result_d;
    logic                    two_byte_q, two_byte_d;
    logic                    tx_lo, tx_hi;
    logic                    tmo_hit;

`ifdef SYS_CMD_TMO_EN
    localparam int unsigned TmoW = $clog2(TMO_CYC + 1);
    logic [TmoW-1:0] tmo_cnt_q;
    logic            byte_wait;

    assign byte_wait = state_q inside {StWrAddr, StWrData, StRdAddr, StOpA, StOpB, StFun};

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tmo_cnt_q <= '0;
        end else if (RX_D_VLD || !byte_wait) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit = byte_wait && !RX_D_VLD && (tmo_cnt_q == TmoW'(TMO_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    assign tx_lo = (state_q == StTxLo);
    assign tx_hi = (state_q == StTxHi);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        alu_en_d   = 1'b0;
        clk_en_d   = clk_en_q;
        fun_d      = fun_q;
        result_d   = result_q;
        two_byte_d = two_byte_q;
        unique case (state_q)
            StIdle: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA)
                        CMD_WR:      state_d = StWrAddr;
                        CMD_RD:      state_d = StRdAddr;
                        CMD_ALU_OP:  state_d = StOpA;
                        CMD_ALU_NOP: state_d = StFun;
                        default:     state_d = StIdle;
                    endcase
                end
            end
            StWrAddr: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = StWrData;
                end
            end
            StWrData: begin
                if (RX_D_VLD) begin
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StRdAddr: begin
                if (RX_D_VLD) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    rd_en_d = 1'b1;
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (RdData_Valid) begin
                    result_d   = {{DATA_W{1'b0}}, RdData};
                    two_byte_d = 1'b0;
                    state_d    = StTxLo;
                end
            end
            StOpA: begin
                if (RX_D_VLD) begin
                    addr_d  = ADDR_W'(OP_A_ADDR);
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    state_d = StOpB;
                end
            end
            StOpB: begin
                if (RX_D_VLD) begin
                    addr_d  = ADDR_W'(OP_B_ADDR);
                    wdata_d = RX_P_DATA;
                    wr_en_d = 1'b1;
                    state_d = StFun;
                end
            end
            StFun: begin
                if (RX_D_VLD) begin
                    fun_d    = RX_P_DATA[3:0];
                    alu_en_d = 1'b1;
                    clk_en_d = 1'b1;
                    state_d  = StAluWait;
                end
            end
            StAluWait: begin
                // CLK_EN drops the cycle after OUT_Valid is seen.
                if (OUT_Valid) begin
                    result_d   = ALU_OUT;
                    two_byte_d = 1'b1;
                    clk_en_d   = 1'b0;
                    state_d    = StTxLo;
                end
            end
            StTxLo: begin
                if (TX_WR) begin
                    state_d = two_byte_q ? StTxHi : StIdle;
                end
            end
            StTxHi: begin
                if (TX_WR) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (tmo_hit) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            alu_en_q   <= 1'b0;
            clk_en_q   <= 1'b0;
            fun_q      <= '0;
            result_q   <= '0;
            two_byte_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            alu_en_q   <= alu_en_d;
            clk_en_q   <= clk_en_d;
            fun_q      <= fun_d;
            result_q   <= result_d;
            two_byte_q <= two_byte_d;
        end
    end

    assign WrEn    = wr_en_q;
    assign RdEn    = rd_en_q;
    assign Address = addr_q;
    assign WrData  = wdata_q;
    assign ALU_FUN = fun_q;
    assign ALU_EN  = alu_en_q;
    assign CLK_EN  = clk_en_q;

    sys_cmd_tx_push #(
        .DATA_W (DATA_W)
    ) u_tx_push (
        .tx_lo_i   (tx_lo),
        .tx_hi_i   (tx_hi),
        .data_i    (result_q),
        .tx_full_i (TX_FULL),
        .tx_data_o (TX_P_DATA),
        .tx_wr_o   (TX_WR)
    );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// Directed self-checking bench for sys_cmd_ctrl; the timeout case runs only
// when SYS_CMD_TMO_EN is defined.
module tb_sys_cmd_ctrl;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned TMO_CYC = 16;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [DATA_W-1:0]     RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  WrEn;
    logic                  RdEn;
    logic [ADDR_W-1:0]     Address;
    logic [DATA_W-1:0]     WrData;
    logic [DATA_W-1:0]     RdData;
    logic                  RdData_Valid;
    logic [3:0]            ALU_FUN;
    logic                  ALU_EN;
    logic                  CLK_EN;
    logic [2*DATA_W-1:0]   ALU_OUT;
    logic                  OUT_Valid;
    logic [DATA_W-1:0]     TX_P_DATA;
    logic                  TX_WR;
    logic                  TX_FULL;

    always #5 CLK = ~CLK;

    sys_cmd_ctrl #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .TMO_CYC (TMO_CYC)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_P_DATA    (RX_P_DATA),
        .RX_D_VLD     (RX_D_VLD),
        .WrEn         (WrEn),
        .RdEn         (RdEn),
        .Address      (Address),
        .WrData       (WrData),
        .RdData       (RdData),
        .RdData_Valid (RdData_Valid),
        .ALU_FUN      (ALU_FUN),
        .ALU_EN       (ALU_EN),
        .CLK_EN       (CLK_EN),
        .ALU_OUT      (ALU_OUT),
        .OUT_Valid    (OUT_Valid),
        .TX_P_DATA    (TX_P_DATA),
        .TX_WR        (TX_WR),
        .TX_FULL      (TX_FULL)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    int alu_cnt = 0;
    int both_cnt = 0;
    logic [ADDR_W+DATA_W-1:0] wr_log[$];
    logic [DATA_W-1:0]        tx_log[$];

    // Mid-cycle observation of pulses and pushes.
    always @(negedge CLK) begin
        if (WrEn) wr_log.push_back({Address, WrData});
        if (TX_WR) tx_log.push_back(TX_P_DATA);
        if (RdEn) rd_cnt++;
        if (ALU_EN) alu_cnt++;
        if (WrEn && RdEn) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK);
        #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD  = 1'b0;
    endtask

    function automatic logic [31:0] tx_at(input int i);
        return (tx_log.size() > i) ? 32'(tx_log[i]) : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] wr_at(input int i);
        return (wr_log.size() > i) ? 32'(wr_log[i]) : 32'hxxxx_xxxx;
    endfunction

    initial begin
        RST = 1'b0;
        RX_P_DATA = '0;
        RX_D_VLD = 1'b0;
        RdData = '0;
        RdData_Valid = 1'b0;
        ALU_OUT = '0;
        OUT_Valid = 1'b0;
        TX_FULL = 1'b0;
        tick(3);
        check_eq("rst_ctrl", {WrEn, RdEn, ALU_EN, CLK_EN, TX_WR}, 0);
        check_eq("rst_addr_data", {Address, WrData}, 0);
        check_eq("rst_fun_tx", {ALU_FUN, TX_P_DATA}, 0);
        RST = 1'b1;
        tick(2);

        // Register write
        wr_log.delete();
        send_byte(8'hAA);
        send_byte(8'h05);
        send_byte(8'h3C);
        check_eq("wr_en", WrEn, 1);
        check_eq("wr_addr", Address, 5);
        check_eq("wr_data", WrData, 8'h3C);
        tick(1);
        check_eq("wr_en_pulse", WrEn, 0);
        tick(2);
        check_eq("wr_count", wr_log.size(), 1);

        // Register read, data returned 3 cycles after RdEn
        tx_log.delete();
        rd_cnt = 0;
        send_byte(8'hBB);
        send_byte(8'h05);
        check_eq("rd_en", RdEn, 1);
        check_eq("rd_addr", Address, 5);
        tick(1);
        check_eq("rd_en_pulse", RdEn, 0);
        tick(2);
        RdData = 8'h3C;
        RdData_Valid = 1'b1;
        tick(1);
        RdData_Valid = 1'b0;
        tick(4);
        check_eq("rd_tx_count", tx_log.size(), 1);
        check_eq("rd_tx_byte", tx_at(0), 8'h3C);
        check_eq("rd_count", rd_cnt, 1);

        // ALU with operands
        tx_log.delete();
        alu_cnt = 0;
        send_byte(8'hCC);
        send_byte(8'h07);
        check_eq("opa_wr", {WrEn, Address, WrData}, {1'b1, 4'h0, 8'h07});
        send_byte(8'h03);
        check_eq("opb_wr", {WrEn, Address, WrData}, {1'b1, 4'h1, 8'h03});
        send_byte(8'h00);
        check_eq("alu_start", {ALU_EN, CLK_EN, ALU_FUN}, {1'b1, 1'b1, 4'h0});
        tick(1);
        check_eq("alu_en_pulse", {ALU_EN, CLK_EN}, 2'b01);
        ALU_OUT = 16'h000A;
        OUT_Valid = 1'b1;
        check_eq("clk_en_at_valid", CLK_EN, 1);
        tick(1);
        OUT_Valid = 1'b0;
        check_eq("clk_en_off", CLK_EN, 0);
        tick(4);
        check_eq("alu_tx_count", tx_log.size(), 2);
        check_eq("alu_tx_lo", tx_at(0), 8'h0A);
        check_eq("alu_tx_hi", tx_at(1), 8'h00);
        check_eq("alu_en_count", alu_cnt, 1);

        // ALU without operands, TX FIFO full for 10 cycles
        tx_log.delete();
        wr_log.delete();
        send_byte(8'hDD);
        send_byte(8'h02);
        check_eq("nop_fun", ALU_FUN, 2);
        TX_FULL = 1'b1;
        ALU_OUT = 16'h1234;
        OUT_Valid = 1'b1;
        tick(1);
        OUT_Valid = 1'b0;
        tick(10);
        check_eq("full_no_push", tx_log.size(), 0);
        check_eq("full_wr_low", TX_WR, 0);
        check_eq("full_data_held", TX_P_DATA, 8'h34);
        TX_FULL = 1'b0;
        tick(4);
        check_eq("full_tx_count", tx_log.size(), 2);
        check_eq("full_tx_lo", tx_at(0), 8'h34);
        check_eq("full_tx_hi", tx_at(1), 8'h12);
        check_eq("nop_no_wr", wr_log.size(), 0);
        check_eq("fun_held", ALU_FUN, 2);

        // Unknown byte ignored, then a write
        wr_log.delete();
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h02);
        send_byte(8'h77);
        tick(2);
        check_eq("unk_wr_count", wr_log.size(), 1);
        check_eq("unk_wr", wr_at(0), 12'h277);

        // Reset mid-frame
        wr_log.delete();
        send_byte(8'hAA);
        send_byte(8'h05);
        RST = 1'b0;
        tick(2);
        check_eq("mid_rst_out", {WrEn, RdEn, ALU_EN, CLK_EN, TX_WR, Address, WrData}, 0);
        check_eq("mid_rst_fun", {ALU_FUN, TX_P_DATA}, 0);
        RST = 1'b1;
        tick(1);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'hFF);
        tick(2);
        check_eq("post_rst_count", wr_log.size(), 1);
        check_eq("post_rst_wr", wr_at(0), 12'h1FF);

`ifdef SYS_CMD_TMO_EN
        // Timeout after 16 silent cycles, next byte decoded as a command
        wr_log.delete();
        rd_cnt = 0;
        send_byte(8'hAA);
        tick(16);
        send_byte(8'hBB);
        send_byte(8'h05);
        check_eq("tmo_rd_en", RdEn, 1);
        tick(2);
        RdData = 8'h11;
        RdData_Valid = 1'b1;
        tick(1);
        RdData_Valid = 1'b0;
        tick(4);
        check_eq("tmo_no_wr", wr_log.size(), 0);
        check_eq("tmo_rd_count", rd_cnt, 1);
`endif

        check_eq("wr_rd_exclusive", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
